// File: rtl/operand_feeder.sv
// rtl/operand_feeder.sv - operand-pair FIFO issuing registered pairs to a downstream pipeline
// Pairs are buffered, then issued in order one per cycle while en is high; flush and reset discard them.
module operand_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             control,
  output logic [1:0]       state,
  output logic [15:0]      issued_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_e;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   out1_q, out1_d;
  logic [WIDTH-1:0]   out2_q, out2_d;
  logic               control_q, control_d;
  logic [15:0]        issued_cnt_q, issued_cnt_d;
  state_e             state_q, state_d;
  logic               push, pop;
  logic [2*WIDTH-1:0] head;

  // Ready comes only from registered count, so a same-cycle pop never frees a slot.
  assign in_ready = (count_q != FULL_CNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count_q != '0) && en && !flush;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out1_d       = out1_q;
    out2_d       = out2_q;
    control_d    = 1'b0;
    issued_cnt_d = issued_cnt_q;
    state_d      = IDLE;
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      issued_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PW'(1);
        out1_d       = head[2*WIDTH-1:WIDTH];
        out2_d       = head[WIDTH-1:0];
        control_d    = 1'b1;
        issued_cnt_d = issued_cnt_q + 16'd1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (count_d != '0) state_d = en ? ACTIVE : STALL;
    end
  end

  // Storage is deliberately left unreset; count and pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out1_q       <= '0;
      out2_q       <= '0;
      control_q    <= 1'b0;
      issued_cnt_q <= '0;
      state_q      <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      control_q    <= control_d;
      issued_cnt_q <= issued_cnt_d;
      state_q      <= state_d;
    end
  end

  assign out1       = out1_q;
  assign out2       = out2_q;
  assign control    = control_q;
  assign state      = state_q;
  assign issued_cnt = issued_cnt_q;
endmodule

// File: tb/tb_operand_feeder.sv
// tb/tb_operand_feeder.sv - directed and randomized checks of operand_feeder against a queue model
module tb_operand_feeder;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] out1, out2;
  logic         control;
  logic [1:0]   state;
  logic [15:0]  issued_cnt;

  operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .en(en), .flush(flush),
    .out1(out1), .out2(out2), .control(control), .state(state),
    .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int pulses = 0;
  bit mvalid = 0;

  logic [2*W-1:0] mq[$];
  logic [W-1:0]   m_out1, m_out2;
  logic           m_ctrl;
  logic [15:0]    m_issued;
  logic [1:0]     m_state;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check ready, advance the model, then sample outputs after the edge.
  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic e, input logic f, input logic r);
    bit do_pop, do_push;
    in_valid = v; in_a = a; in_b = b; en = e; flush = f; rst = r;
    #1;
    if (mvalid) check("in_ready", in_ready, mq.size() < D);
    if (!r) begin
      mq.delete();
      m_out1 = '0; m_out2 = '0; m_ctrl = 0; m_issued = '0; m_state = 2'd0;
      mvalid = 1;
    end else if (f) begin
      mq.delete();
      m_ctrl = 0; m_issued = '0; m_state = 2'd0;
    end else begin
      do_pop  = (mq.size() != 0) && e;
      do_push = v && (mq.size() < D);
      m_ctrl = do_pop;
      if (do_pop) begin
        {m_out1, m_out2} = mq.pop_front();
        m_issued = m_issued + 16'd1;
      end
      if (do_push) mq.push_back({a, b});
      m_state = (mq.size() == 0) ? 2'd0 : (e ? 2'd1 : 2'd2);
    end
    @(posedge clk);
    #1;
    if (mvalid) begin
      check("out1", out1, m_out1);
      check("out2", out2, m_out2);
      check("control", control, m_ctrl);
      check("state", state, m_state);
      check("issued_cnt", issued_cnt, m_issued);
    end
    if (control === 1'b1) pulses++;
  endtask

  task automatic idle(input logic e);
    cyc(0, '0, '0, e, 0, 1);
  endtask

  task automatic do_reset();
    cyc(0, '0, '0, 0, 0, 0);
    cyc(0, '0, '0, 0, 0, 0);
  endtask

  initial begin
    logic [W-1:0] nxt;
    // Reset state and ready after release
    do_reset();
    check("reset_out1", out1, 32'h0);
    check("reset_state", state, 2'd0);
    check("reset_ready", in_ready, 1'b1);

    // Basic issue: control two edges after push
    cyc(1, 32'h0000000F, 32'h000000FF, 1, 0, 1);
    check("basic_no_bypass", control, 1'b0);
    idle(1);
    check("basic_ctrl", control, 1'b1);
    check("basic_out1", out1, 32'h0000000F);
    check("basic_out2", out2, 32'h000000FF);
    check("basic_cnt", issued_cnt, 16'd1);
    check("basic_idle", state, 2'd0);

    // Fill and stall, then drain
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      cyc(1, W'(i), W'(i + 100), 0, 0, 1);
      if (i == 4) check("full_ready", in_ready, 1'b0);
    end
    check("stall_state", state, 2'd2);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      check("drain_ctrl", control, 1'b1);
      check("drain_out1", out1, W'(i));
      if (i == 1) check("ready_after_pop", in_ready, 1'b1);
    end
    idle(1);
    check("drain_done", control, 1'b0);

    // Concurrent push/pop for 20 cycles
    do_reset();
    pulses = 0;
    nxt = 32'd1;
    for (int i = 1; i <= 22; i++) begin
      cyc(i <= 20, W'(i), ~W'(i), 1, 0, 1);
      check("conc_depth", mq.size() <= 1, 1'b1);
      if (control === 1'b1) begin
        check("conc_order", out1, nxt);
        nxt++;
      end
    end
    check("conc_pulses", pulses, 20);
    check("conc_cnt", issued_cnt, 16'd20);

    // Flush discards buffered pairs
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, W'(i + 7), W'(i), 0, 0, 1);
    cyc(0, '0, '0, 0, 1, 1);
    check("flush_state", state, 2'd0);
    check("flush_cnt", issued_cnt, 16'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("flush_no_issue", control, 1'b0);
    end

    // Reset mid-stream, with a push offered during reset
    do_reset();
    cyc(1, 32'hAA, 32'hBB, 1, 0, 1);
    cyc(1, 32'hCC, 32'hDD, 0, 0, 1);
    cyc(1, 32'hEE, 32'hFF, 0, 0, 1);
    cyc(1, 32'h11, 32'h22, 1, 0, 0);
    check("rst_out1", out1, 32'h0);
    check("rst_out2", out2, 32'h0);
    check("rst_ctrl", control, 1'b0);
    check("rst_state", state, 2'd0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check("rst_no_issue", control, 1'b0);
    end

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 3) != 0,
          $urandom_range(0, 40) == 0, $urandom_range(0, 80) != 0);

    // issued_cnt wrap and pointer wrap across 65536 issues
    do_reset();
    pulses = 0;
    for (int i = 0; i < 65538; i++) begin
      cyc(i < 65536, $urandom, $urandom, 1, 0, 1);
      if (pulses == 65535 && control === 1'b1) check("wrap_max", issued_cnt, 16'hFFFF);
    end
    check("wrap_pulses", pulses, 65536);
    check("wrap_zero", issued_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
